// File: rtl/div_unit_pkg.sv
// Shared RV32M divider definitions: M-extension encodings, funct3 codes and FSM states.
package div_unit_pkg;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_CALC = 2'b01;
    localparam logic [1:0] DIV_DONE = 2'b10;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == INST_DIV) || (op == INST_REM);
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return (op == INST_REM) || (op == INST_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Works on operand magnitudes, one quotient bit per cycle, sign fix-up on entry to DONE.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      div_start_i,
    input  logic [2:0]                div_op_i,
    input  logic [DATA_WIDTH-1:0]     div_dividend_i,
    input  logic [DATA_WIDTH-1:0]     div_divisor_i,
    input  logic [REG_ADDR_WIDTH-1:0] div_rd_addr_i,
    input  logic                      div_abort_i,
    output logic                      div_busy_o,
    output logic                      div_ready_o,
    output logic [DATA_WIDTH-1:0]     div_result_o,
    output logic [REG_ADDR_WIDTH-1:0] div_rd_addr_o,
    output logic                      div_rd_wr_en_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [DATA_WIDTH-1:0]     dvd_q, dvd_d;
    logic [DATA_WIDTH-1:0]     dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0]     rem_q, rem_d;
    logic [DATA_WIDTH-1:0]     quo_q, quo_d;
    logic [2:0]                op_q, op_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                      dvd_neg_q, dvd_neg_d;
    logic                      dvs_neg_q, dvs_neg_d;
    logic [DATA_WIDTH-1:0]     result_q, result_d;
    logic [REG_ADDR_WIDTH-1:0] rd_out_q, rd_out_d;
    logic                      ready_q, ready_d;

    logic                      is_signed_s;
    logic [DATA_WIDTH:0]       rem_ext_s;
    logic [DATA_WIDTH:0]       diff_s;
    logic                      ge_s;
    logic [DATA_WIDTH-1:0]     quo_fix_s;
    logic [DATA_WIDTH-1:0]     rem_fix_s;

    // Next-state logic: capture, iteration and sign fix-up.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        op_d        = op_q;
        rd_addr_d   = rd_addr_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        result_d    = result_q;
        rd_out_d    = rd_out_q;
        ready_d     = 1'b0;
        is_signed_s = 1'b0;
        rem_ext_s   = '0;
        diff_s      = '0;
        ge_s        = 1'b0;
        quo_fix_s   = '0;
        rem_fix_s   = '0;

        case (state_q)
            DIV_IDLE: begin
                if (div_start_i && !div_abort_i) begin
                    is_signed_s = op_is_signed(div_op_i);
                    op_d        = div_op_i;
                    rd_addr_d   = div_rd_addr_i;
                    dvd_neg_d   = is_signed_s & div_dividend_i[DATA_WIDTH-1];
                    dvs_neg_d   = is_signed_s & div_divisor_i[DATA_WIDTH-1];
                    dvd_d       = dvd_neg_d ? -div_dividend_i : div_dividend_i;
                    dvs_d       = dvs_neg_d ? -div_divisor_i : div_divisor_i;
                    rem_d       = '0;
                    quo_d       = '0;
                    count_d     = CNT_W'(DATA_WIDTH - 1);
                    if (div_divisor_i == '0) begin
                        state_d  = DIV_DONE;
                        ready_d  = 1'b1;
                        rd_out_d = div_rd_addr_i;
                        result_d = op_is_rem(div_op_i) ? div_dividend_i : '1;
                    end else begin
                        state_d = DIV_CALC;
                    end
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_CALC: begin
                // The shifted-out remainder MSB is kept so large divisors still compare correctly.
                rem_ext_s = {rem_q, dvd_q[DATA_WIDTH-1]};
                diff_s    = rem_ext_s - {1'b0, dvs_q};
                ge_s      = ~diff_s[DATA_WIDTH];
                rem_d     = ge_s ? diff_s[DATA_WIDTH-1:0] : rem_ext_s[DATA_WIDTH-1:0];
                quo_d     = {quo_q[DATA_WIDTH-2:0], ge_s};
                dvd_d     = dvd_q << 1;
                count_d   = count_q - 1'b1;
                quo_fix_s = (dvd_neg_q ^ dvs_neg_q) ? -quo_d : quo_d;
                rem_fix_s = dvd_neg_q ? -rem_d : rem_d;
                if (div_abort_i) begin
                    state_d = DIV_IDLE;
                end else if (count_q == '0) begin
                    state_d  = DIV_DONE;
                    ready_d  = 1'b1;
                    rd_out_d = rd_addr_q;
                    result_d = op_is_rem(op_q) ? rem_fix_s : quo_fix_s;
                end else begin
                    state_d = DIV_CALC;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            count_q   <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            op_q      <= 3'b000;
            rd_addr_q <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            op_q      <= op_d;
            rd_addr_q <= rd_addr_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
            ready_q   <= ready_d;
        end
    end

    assign div_busy_o     = (state_q != DIV_IDLE);
    assign div_ready_o    = ready_q;
    assign div_rd_wr_en_o = ready_q;
    assign div_result_o   = result_q;
    assign div_rd_addr_o  = rd_out_q;

endmodule
